execute_mul_sequencer: RTL
==========================

Name: execute_mul_sequencer

Overview:
Multi-cycle 16x16 shift-add multiply sequencer that borrows the execute-stage ALU for its adds. While a multiply runs it owns the ALU operand/control inputs and stalls the pipeline. Each iteration issues one 16-bit add and accumulates a 32-bit product. Sits beside the execute stage; the ALU input muxes select this block's outputs when o_ALU_Own is high.

Parameters:
- WIDTH, 16, operand width; product is 2*WIDTH.
- CNT_W, 4, iteration counter width; must satisfy 2**CNT_W == WIDTH.

Ports:
- i_Clk  input  1  clock, rising edge.
- i_Rst_n  input  1  reset, asynchronous, active-low.
- i_Start  input  1  request a multiply; sampled only in IDLE.
- i_Signed  input  1  signed multiply select; honoured only with the optional feature.
- i_Flush  input  1  abort an in-flight multiply.
- i_Multiplicand  input  WIDTH  operand A.
- i_Multiplier  input  WIDTH  operand B.
- i_ALU_Result  input  WIDTH  ALU result for the operands driven this cycle.
- o_ALU_Own  output  1  ALU inputs sourced from this block.
- o_ALU_A  output  WIDTH  ALU operand A.
- o_ALU_B  output  WIDTH  ALU operand B.
- o_ALU_Control  output  3  ALU control; always the ADD code.
- o_Busy  output  1  multiply in progress.
- o_Stall  output  1  pipeline stall request.
- o_Done  output  1  one-cycle pulse: product valid.
- o_Product  output  2*WIDTH  result; held until the next accepted start.

Behaviour:
- Clock and reset: one clock, i_Clk. Reset is asynchronous and active-low (i_Rst_n).
- Reset values: state IDLE; counter, accumulators, o_Product = 0; o_Busy, o_Done, o_ALU_Own = 0. o_ALU_A, o_ALU_B = 0. o_ALU_Control = ALU_CTRL_ADD.
- States: IDLE, ITER, DONE.
- IDLE:
  - i_Start=1 at an edge: capture operands (acc_hi=0, acc_lo=multiplier, mcand=multiplicand), clear counter, go to ITER.
  - o_Stall = i_Start (combinational), so the instruction holds in the execute stage.
- ITER (o_Busy=1, o_ALU_Own=1, o_Stall=1):
  - o_ALU_A = acc_hi.
  - o_ALU_B = acc_lo[0] ? mcand : 0.
  - carry = (i_ALU_Result < acc_hi), unsigned compare.
  - Each edge: {acc_hi, acc_lo} <= {carry, i_ALU_Result, acc_lo[WIDTH-1:1]}; counter+1.
  - Counter == WIDTH-1 at the edge: go to DONE.
- DONE (o_Busy=1, o_Stall=1, o_ALU_Own=0): o_Done=1 for exactly this cycle. Next edge: o_Product <= {acc_hi, acc_lo}, go to IDLE.
- Latency: start sampled at edge N; o_Done high in the cycle after edge N+WIDTH (17th cycle). o_Product updates at edge N+WIDTH+1.
- o_Product is also presented combinationally during DONE: o_Product is muxed to the accumulator while o_Done=1, so it is valid when o_Done is seen.
- i_Start while o_Busy: ignored, no queuing.
- i_Flush in ITER or DONE: next edge goes to IDLE. No o_Done; o_Product unchanged. i_Flush in IDLE wins over i_Start.
- Reset mid-operation: immediate return to reset values, no o_Done.
- Operands 0 or 1 take full latency; no early exit.

Optional Feature:
- Macro: EXEC_MUL_SIGNED_EN.
- Defined, i_Signed=1 at start:
  - Capture magnitudes of both operands. -32768 is magnitude 0x8000, unsigned.
  - Record neg = A[15]^B[15].
  - On DONE, the product presented (and registered) is the 32-bit two's-complement negation of the accumulator if neg.
  - Negation is internal logic, not the ALU; latency unchanged.
- Not defined: i_Signed is ignored; all multiplies are unsigned.

Decomposition:
- Package exec_pkg holds:
  - ALU_CTRL_ADD (3'b010) and the other ALU control codes shared with ALU_control.
  - State encoding constants S_IDLE, S_ITER, S_DONE.
  - MUL_WIDTH = 16.
- One natural sub-module: mul_accumulator, covering the acc_hi/acc_lo shift register, carry compare and optional negation. The FSM and counter stay in the top.

Test Plan:
- 3*5, unsigned, start at edge N -> o_Done in the cycle after edge N+16. Product 0x0000000F; o_Stall high throughout; o_ALU_Control=ADD every ITER cycle.
- 0xFFFF*0xFFFF -> product 0xFFFE0001. Checks carry recovery on every iteration.
- Start, then i_Start pulsed again at iteration 5 -> ignored. Single o_Done, correct product 0x1234*0x0010 = 0x00012340.
- i_Flush at iteration 8 of 7*9 -> IDLE next cycle, no o_Done. o_Product keeps the previous value; a new 2*2 then yields 4.
- i_Rst_n low at iteration 10 -> all outputs at reset values immediately (asynchronous). Release then 6*7 -> 0x2A.
- With EXEC_MUL_SIGNED_EN, i_Signed=1:
  - -3*5 -> 0xFFFFFFF1.
  - -32768*-1 -> 0x00008000.
  - Without the macro, -3*5 -> 0x0004FFF1.

Source files
------------

// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared execute-stage constants for the multiply sequencer
//
// Purpose: ALU control codes shared with ALU_control, sequencer state
//          encoding and the default multiply width.
// Ports:   none (package).
package exec_pkg;

   localparam int MUL_WIDTH = 16;

   // ALU control codes; the sequencer only ever issues ALU_CTRL_ADD.
   typedef enum logic [2:0] {
      ALU_CTRL_AND = 3'b000,
      ALU_CTRL_OR  = 3'b001,
      ALU_CTRL_ADD = 3'b010,
      ALU_CTRL_SUB = 3'b110,
      ALU_CTRL_SLT = 3'b111
   } alu_ctrl_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_DONE = 2'd2
   } mul_state_t;

endpackage

// File: rtl/mul_accumulator.sv
// rtl/mul_accumulator.sv - shift-add accumulator datapath for the multiply sequencer
//
// Purpose: holds acc_hi/acc_lo/multiplicand, folds each ALU add result back
//          into the shift register with its recovered carry, and presents the
//          final product (negated for signed multiplies when
//          EXEC_MUL_SIGNED_EN is defined).
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_load           capture operands (acc_hi=0, acc_lo=B, mcand=A)
//   i_step           perform one shift-add iteration
//   i_signed_sel     signed multiply request (used only with EXEC_MUL_SIGNED_EN)
//   i_multiplicand   operand A
//   i_multiplier     operand B
//   i_alu_result     ALU sum of acc_hi and the selected addend
//   o_acc_hi         upper accumulator half (ALU operand A)
//   o_acc_lo0        current multiplier bit (selects ALU operand B)
//   o_mcand          captured multiplicand
//   o_result         full product, sign-corrected
module mul_accumulator
   import exec_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_load,
   input  logic               i_step,
   input  logic               i_signed_sel,
   input  logic [WIDTH-1:0]   i_multiplicand,
   input  logic [WIDTH-1:0]   i_multiplier,
   input  logic [WIDTH-1:0]   i_alu_result,
   output logic [WIDTH-1:0]   o_acc_hi,
   output logic               o_acc_lo0,
   output logic [WIDTH-1:0]   o_mcand,
   output logic [2*WIDTH-1:0] o_result
);

   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] load_a, load_b;
   logic             carry;

   // The ALU is only 16 bits wide; a wrapped sum is always smaller than the
   // non-negative acc_hi it started from, which recovers bit 16.
   assign carry = (i_alu_result < acc_hi_q);

`ifdef EXEC_MUL_SIGNED_EN
   logic neg_q, neg_d;

   // Magnitudes; -2**(WIDTH-1) negates to itself, which read unsigned is correct.
   assign load_a = (i_signed_sel && i_multiplicand[WIDTH-1]) ? -i_multiplicand : i_multiplicand;
   assign load_b = (i_signed_sel && i_multiplier[WIDTH-1])   ? -i_multiplier   : i_multiplier;
   assign o_result = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};

   always_comb begin
      neg_d = neg_q;
      if (i_load) begin
         neg_d = i_signed_sel & (i_multiplicand[WIDTH-1] ^ i_multiplier[WIDTH-1]);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         neg_q <= 1'b0;
      end else begin
         neg_q <= neg_d;
      end
   end
`else
   logic unused_signed_sel;

   assign unused_signed_sel = i_signed_sel;
   assign load_a   = i_multiplicand;
   assign load_b   = i_multiplier;
   assign o_result = {acc_hi_q, acc_lo_q};
`endif

   always_comb begin
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      mcand_d  = mcand_q;
      if (i_load) begin
         acc_hi_d = '0;
         acc_lo_d = load_b;
         mcand_d  = load_a;
      end else if (i_step) begin
         // {acc_hi, acc_lo} <= {carry, sum, acc_lo[WIDTH-1:1]}
         acc_hi_d = {carry, i_alu_result[WIDTH-1:1]};
         acc_lo_d = {i_alu_result[0], acc_lo_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         mcand_q  <= '0;
      end else begin
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         mcand_q  <= mcand_d;
      end
   end

   assign o_acc_hi  = acc_hi_q;
   assign o_acc_lo0 = acc_lo_q[0];
   assign o_mcand   = mcand_q;

endmodule

// File: rtl/execute_mul_sequencer.sv
// rtl/execute_mul_sequencer.sv - 16x16 shift-add multiply sequencer using the execute-stage ALU
//
// Purpose: takes over the execute-stage ALU for WIDTH iterations, stalling the
//          pipeline, and produces a 2*WIDTH product. Optional signed support
//          is enabled by defining EXEC_MUL_SIGNED_EN.
// Ports:
//   i_Clk, i_Rst_n        clock, asynchronous active-low reset
//   i_Start               multiply request (sampled in IDLE only)
//   i_Signed              signed select (EXEC_MUL_SIGNED_EN builds only)
//   i_Flush               abort in-flight multiply; beats i_Start in IDLE
//   i_Multiplicand/i_Multiplier  operands
//   i_ALU_Result          ALU result for o_ALU_A/o_ALU_B this cycle
//   o_ALU_Own             ALU input muxes select this block
//   o_ALU_A/o_ALU_B       ALU operands
//   o_ALU_Control         always ALU_CTRL_ADD
//   o_Busy, o_Stall       multiply in progress / pipeline stall
//   o_Done                one-cycle product-valid pulse
//   o_Product             product; valid with o_Done, held until next result
module execute_mul_sequencer
   import exec_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH,
   parameter int CNT_W = 4
) (
   input  logic               i_Clk,
   input  logic               i_Rst_n,
   input  logic               i_Start,
   input  logic               i_Signed,
   input  logic               i_Flush,
   input  logic [WIDTH-1:0]   i_Multiplicand,
   input  logic [WIDTH-1:0]   i_Multiplier,
   input  logic [WIDTH-1:0]   i_ALU_Result,
   output logic               o_ALU_Own,
   output logic [WIDTH-1:0]   o_ALU_A,
   output logic [WIDTH-1:0]   o_ALU_B,
   output logic [2:0]         o_ALU_Control,
   output logic               o_Busy,
   output logic               o_Stall,
   output logic               o_Done,
   output logic [2*WIDTH-1:0] o_Product
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   mul_state_t         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] product_q, product_d;
   logic               load, step;
   logic [WIDTH-1:0]   acc_hi;
   logic               acc_lo0;
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] acc_result;

   mul_accumulator #(
      .WIDTH (WIDTH)
   ) u_acc (
      .i_clk          (i_Clk),
      .i_rst_n        (i_Rst_n),
      .i_load         (load),
      .i_step         (step),
      .i_signed_sel   (i_Signed),
      .i_multiplicand (i_Multiplicand),
      .i_multiplier   (i_Multiplier),
      .i_alu_result   (i_ALU_Result),
      .o_acc_hi       (acc_hi),
      .o_acc_lo0      (acc_lo0),
      .o_mcand        (mcand),
      .o_result       (acc_result)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      load      = 1'b0;
      step      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_Start && !i_Flush) begin
               load    = 1'b1;
               cnt_d   = '0;
               state_d = S_ITER;
            end
         end
         S_ITER: begin
            if (i_Flush) begin
               state_d = S_IDLE;
            end else begin
               step  = 1'b1;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_ITER) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            if (!i_Flush) begin
               product_d = acc_result;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   assign o_Busy        = (state_q != S_IDLE);
   assign o_ALU_Own     = (state_q == S_ITER);
   assign o_ALU_A       = o_ALU_Own ? acc_hi : '0;
   assign o_ALU_B       = (o_ALU_Own && acc_lo0) ? mcand : '0;
   assign o_ALU_Control = ALU_CTRL_ADD;
   // In IDLE the stall follows i_Start so the instruction holds before capture.
   assign o_Stall       = o_Busy | i_Start;
   // A flush in DONE suppresses the completion pulse.
   assign o_Done        = (state_q == S_DONE) && !i_Flush;
   assign o_Product     = o_Done ? acc_result : product_q;

endmodule
